// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a multi-digit 7-segment display.
// Latency: outputs registered, aligned with the scan state; a new value is committed at the frame boundary.
// Backpressure: load_ready drops while a load is pending, until the next frame boundary.
// Optional macro SSD_LEADING_ZERO_BLANK_EN: keeps leading-zero digits dark during their SHOW interval.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              dig_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_MAX = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              dig_q, dig_d;
  logic                    frame_done_q;
  logic                    boundary;
  logic                    xfer;
  logic [NUM_DIGITS-1:0]   lit;

  // State, counters, value buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      buf_q        <= '0;
      pending_q    <= 1'b0;
      an_q         <= '0;
      dig_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      buf_q        <= buf_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      dig_q        <= dig_d;
      frame_done_q <= boundary;
    end
  end

  // Scan sequencing: BLANK -> SHOW per digit; boundary is the last SHOW cycle of the top digit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = BLANK;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = BLANK;
      end
    endcase
  end

  // Load handshake: capture into the pending buffer, commit (or bypass) only at the frame boundary.
  always_comb begin
    xfer      = load_valid && !pending_q;
    shadow_d  = shadow_q;
    buf_d     = buf_q;
    pending_d = pending_q;
    if (boundary) begin
      if (pending_q) begin
        shadow_d  = buf_q;
        pending_d = 1'b0;
      end else if (xfer) begin
        shadow_d = load_data;
      end
    end else if (xfer) begin
      buf_d     = load_data;
      pending_d = 1'b1;
    end
  end

  // Digit lighting mask: leading zeros optionally stay dark, digit 0 always lights.
`ifdef SSD_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic nz;
    nz  = 1'b0;
    lit = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz     = nz | (|shadow_d[4*i +: 4]);
      lit[i] = nz || (i == 0);
    end
  end
`else
  always_comb begin
    lit = '1;
  end
`endif

  // Next outputs follow the next scan state so registered outputs line up with the state.
  always_comb begin
    an_d  = '0;
    dig_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        dig_d   = shadow_d[4*i +: 4];
        an_d[i] = (state_d == SHOW) && lit[i];
      end
    end
  end

  assign load_ready = !pending_q;
  assign an         = an_q;
  assign dig_out    = dig_q;
  assign frame_done = frame_done_q;

endmodule
